// File: rtl/branch_issue_ctrl_pkg.sv
// Shared definitions for the branch issue sequencer: issue codes, FSM
// encoding and default opcode/funct values.
package branch_issue_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] NIS_NONE  = 3'b000;
    localparam logic [2:0] NIS_BMV   = 3'b001;
    localparam logic [2:0] NIS_BZ    = 3'b010;
    localparam logic [2:0] NIS_JSP   = 3'b100;
    localparam logic [2:0] NIS_BALRN = 3'b101;
    localparam logic [2:0] NIS_JMADD = 3'b110;

    localparam logic [5:0] OP_RTYPE_DEF = 6'h00;
    localparam logic [5:0] OP_BZ_DEF    = 6'h18;
    localparam logic [5:0] OP_JSP_DEF   = 6'h1c;
    localparam logic [5:0] FN_BMV_DEF   = 6'h14;
    localparam logic [5:0] FN_JMADD_DEF = 6'h15;
    localparam logic [5:0] FN_BALRN_DEF = 6'h16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ISSUE    = 2'd2
    } state_t;

    // Branches that redirect through a word fetched from data memory.
    function automatic logic nis_needs_mem(input logic [2:0] code);
        return (code == NIS_BMV) || (code == NIS_JSP) || (code == NIS_JMADD);
    endfunction

endpackage

// File: rtl/branch_decode.sv
// Combinational map from opcode/funct to the issue code and whether the
// branch must first read data memory.
module branch_decode
    import branch_issue_ctrl_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = OP_RTYPE_DEF,
    parameter logic [5:0] OP_BZ    = OP_BZ_DEF,
    parameter logic [5:0] OP_JSP   = OP_JSP_DEF,
    parameter logic [5:0] FN_BMV   = FN_BMV_DEF,
    parameter logic [5:0] FN_JMADD = FN_JMADD_DEF,
    parameter logic [5:0] FN_BALRN = FN_BALRN_DEF
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] code,
    output logic       needs_mem
);

    always_comb begin
        code = NIS_NONE;
        if (opcode == OP_BZ) begin
            code = NIS_BZ;
        end else if (opcode == OP_JSP) begin
            code = NIS_JSP;
        end else if (opcode == OP_RTYPE) begin
            case (funct)
                FN_BMV:   code = NIS_BMV;
                FN_JMADD: code = NIS_JMADD;
                FN_BALRN: code = NIS_BALRN;
                default:  code = NIS_NONE;
            endcase
        end
    end

    assign needs_mem = nis_needs_mem(code);

endmodule

// File: rtl/branch_issue_ctrl.sv
// Issue-side sequencer: decodes extended branches, fetches the redirect word
// for memory-based branches, and presents a one-cycle nis code with flags.
module branch_issue_ctrl
    import branch_issue_ctrl_pkg::*;
#(
    parameter int         DATA_W   = branch_issue_ctrl_pkg::DATA_W,
    parameter logic [5:0] OP_RTYPE = OP_RTYPE_DEF,
    parameter logic [5:0] OP_BZ    = OP_BZ_DEF,
    parameter logic [5:0] OP_JSP   = OP_JSP_DEF,
    parameter logic [5:0] FN_BMV   = FN_BMV_DEF,
    parameter logic [5:0] FN_JMADD = FN_JMADD_DEF,
    parameter logic [5:0] FN_BALRN = FN_BALRN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] mem_addr_in,
    input  logic              flag_we,
    input  logic              n_in,
    input  logic              z_in,
    input  logic              v_in,
    output logic              mem_rd_req,
    output logic [DATA_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [2:0]        nis,
    output logic              n,
    output logic              z,
    output logic              v,
    output logic [DATA_W-1:0] mem_out,
    output logic              stall
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] pend_q;
    logic [2:0] pend_d;
    logic [2:0] nis_d;
    logic       load_addr;
    logic [2:0] dec_code;
    logic       dec_needs_mem;
    logic       capture;

    branch_decode #(
        .OP_RTYPE (OP_RTYPE),
        .OP_BZ    (OP_BZ),
        .OP_JSP   (OP_JSP),
        .FN_BMV   (FN_BMV),
        .FN_JMADD (FN_JMADD),
        .FN_BALRN (FN_BALRN)
    ) u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .code      (dec_code),
        .needs_mem (dec_needs_mem)
    );

    // Request and stall are pure state decodes so an async reset drops them at once.
    assign stall      = (state_q == ST_MEM_WAIT);
    assign mem_rd_req = (state_q == ST_MEM_WAIT);
    assign capture    = stall && mem_rd_ack;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        nis_d     = NIS_NONE;
        load_addr = 1'b0;
        case (state_q)
            ST_MEM_WAIT: begin
                if (mem_rd_ack) begin
                    state_d = ST_ISSUE;
                    nis_d   = pend_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (instr_valid && (dec_code != NIS_NONE)) begin
                    if (dec_needs_mem) begin
                        state_d   = ST_MEM_WAIT;
                        pend_d    = dec_code;
                        load_addr = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        nis_d   = dec_code;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= NIS_NONE;
            nis         <= NIS_NONE;
            mem_rd_addr <= '0;
            mem_out     <= '0;
            n           <= 1'b0;
            z           <= 1'b0;
            v           <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            nis     <= nis_d;
            if (load_addr) begin
                mem_rd_addr <= mem_addr_in;
            end
            if (capture) begin
                mem_out <= mem_rd_data;
            end
            // Flags updated in the acceptance cycle are visible alongside nis.
            if (flag_we && !stall) begin
                n <= n_in;
                z <= z_in;
                v <= v_in;
            end
        end
    end

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Directed bench for branch_issue_ctrl, checked each cycle against a
// transaction-level model plus hand-computed literal expectations.
module tb_branch_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [31:0] mem_addr_in = '0;
    logic        flag_we = 1'b0;
    logic        n_in = 1'b0;
    logic        z_in = 1'b0;
    logic        v_in = 1'b0;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic [2:0]  nis;
    logic        n;
    logic        z;
    logic        v;
    logic [31:0] mem_out;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    branch_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .funct       (funct),
        .mem_addr_in (mem_addr_in),
        .flag_we     (flag_we),
        .n_in        (n_in),
        .z_in        (z_in),
        .v_in        (v_in),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .nis         (nis),
        .n           (n),
        .z           (z),
        .v           (v),
        .mem_out     (mem_out),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    // Reference model: "waiting for memory" flag plus the branch it owes.
    bit          m_wait;
    logic [2:0]  m_pend;
    logic [2:0]  m_nis;
    logic [31:0] m_addr;
    logic [31:0] m_out;
    logic        m_n, m_z, m_v;

    function automatic logic [2:0] spec_code(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h18) return 3'b010;
        if (op == 6'h1c) return 3'b100;
        if (op == 6'h00) begin
            if (fn == 6'h14) return 3'b001;
            if (fn == 6'h15) return 3'b110;
            if (fn == 6'h16) return 3'b101;
        end
        return 3'b000;
    endfunction

    function automatic bit reads_mem(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b100) || (c == 3'b110);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait <= 1'b0;
            m_pend <= 3'b000;
            m_nis  <= 3'b000;
            m_addr <= 32'h0;
            m_out  <= 32'h0;
            m_n    <= 1'b0;
            m_z    <= 1'b0;
            m_v    <= 1'b0;
        end else begin
            if (flag_we && !m_wait) begin
                m_n <= n_in;
                m_z <= z_in;
                m_v <= v_in;
            end
            if (m_wait) begin
                m_nis <= mem_rd_ack ? m_pend : 3'b000;
                if (mem_rd_ack) begin
                    m_out  <= mem_rd_data;
                    m_wait <= 1'b0;
                end
            end else if (instr_valid && reads_mem(spec_code(opcode, funct))) begin
                m_wait <= 1'b1;
                m_pend <= spec_code(opcode, funct);
                m_addr <= mem_addr_in;
                m_nis  <= 3'b000;
            end else begin
                m_nis <= instr_valid ? spec_code(opcode, funct) : 3'b000;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model.nis", {29'd0, nis}, {29'd0, m_nis});
        chk("model.n", {31'd0, n}, {31'd0, m_n});
        chk("model.z", {31'd0, z}, {31'd0, m_z});
        chk("model.v", {31'd0, v}, {31'd0, m_v});
        chk("model.stall", {31'd0, stall}, {31'd0, m_wait});
        chk("model.mem_rd_req", {31'd0, mem_rd_req}, {31'd0, m_wait});
        chk("model.mem_rd_addr", mem_rd_addr, m_addr);
        chk("model.mem_out", mem_out, m_out);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        opcode      = 6'h00;
        funct       = 6'h00;
        mem_addr_in = 32'h0;
        flag_we     = 1'b0;
        n_in        = 1'b0;
        z_in        = 1'b0;
        v_in        = 1'b0;
        mem_rd_ack  = 1'b0;
        mem_rd_data = 32'h0;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] addr);
        instr_valid = 1'b1;
        opcode      = op;
        funct       = fn;
        mem_addr_in = addr;
    endtask

    initial begin
        idle();
        cyc();
        cyc();
        chk("reset.nis", {29'd0, nis}, 32'h0);
        chk("reset.stall", {31'd0, stall}, 32'h0);
        chk("reset.mem_rd_addr", mem_rd_addr, 32'h0);
        rst_n = 1'b1;
        cyc();

        // bz with a same-cycle flag update
        instr(6'h18, 6'h00, 32'h0);
        flag_we = 1'b1;
        z_in    = 1'b1;
        cyc();
        chk("bz.nis", {29'd0, nis}, 32'h2);
        chk("bz.z", {31'd0, z}, 32'h1);
        chk("bz.stall", {31'd0, stall}, 32'h0);
        idle();
        cyc();
        chk("bz.nis_clear", {29'd0, nis}, 32'h0);

        // jmadd with ack in the third wait cycle
        instr(6'h00, 6'h15, 32'h0000_0040);
        cyc();
        chk("jmadd.req1", {31'd0, mem_rd_req}, 32'h1);
        chk("jmadd.addr", mem_rd_addr, 32'h40);
        idle();
        cyc();
        chk("jmadd.stall2", {31'd0, stall}, 32'h1);
        cyc();
        chk("jmadd.stall3", {31'd0, stall}, 32'h1);
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'h0040_0100;
        cyc();
        chk("jmadd.nis", {29'd0, nis}, 32'h6);
        chk("jmadd.mem_out", mem_out, 32'h0040_0100);
        chk("jmadd.req_drop", {31'd0, mem_rd_req}, 32'h0);
        idle();
        cyc();
        chk("jmadd.nis_clear", {29'd0, nis}, 32'h0);

        // bmv, then balrn held while stalled
        instr(6'h00, 6'h14, 32'h0000_0080);
        cyc();
        instr(6'h00, 6'h16, 32'h0);
        cyc();
        chk("bmv.stall_hold", {31'd0, stall}, 32'h1);
        chk("bmv.nis_quiet", {29'd0, nis}, 32'h0);
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'hA5A5_5A5A;
        cyc();
        chk("bmv.nis", {29'd0, nis}, 32'h1);
        chk("bmv.mem_out", mem_out, 32'hA5A5_5A5A);
        mem_rd_ack = 1'b0;
        cyc();
        chk("balrn.after_bmv", {29'd0, nis}, 32'h5);
        idle();
        cyc();

        // back-to-back balrn, bz, non-branch
        instr(6'h00, 6'h16, 32'h0);
        cyc();
        chk("b2b.balrn", {29'd0, nis}, 32'h5);
        instr(6'h18, 6'h00, 32'h0);
        cyc();
        chk("b2b.bz", {29'd0, nis}, 32'h2);
        chk("b2b.stall", {31'd0, stall}, 32'h0);
        instr(6'h00, 6'h20, 32'h0);
        cyc();
        chk("b2b.none", {29'd0, nis}, 32'h0);
        instr(6'h23, 6'h14, 32'h0);
        cyc();
        chk("nonbr.opcode", {29'd0, nis}, 32'h0);
        chk("nonbr.stall", {31'd0, stall}, 32'h0);

        // jsp acked in the first wait cycle
        instr(6'h1c, 6'h00, 32'h0000_0200);
        cyc();
        idle();
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'h1234_5678;
        cyc();
        chk("jsp.fast_nis", {29'd0, nis}, 32'h4);
        chk("jsp.fast_out", mem_out, 32'h1234_5678);
        idle();
        cyc();

        // reset during jsp wait
        instr(6'h1c, 6'h00, 32'h0000_0100);
        flag_we = 1'b1;
        n_in    = 1'b1;
        cyc();
        chk("jsp.n_set", {31'd0, n}, 32'h1);
        chk("jsp.req", {31'd0, mem_rd_req}, 32'h1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst.req", {31'd0, mem_rd_req}, 32'h0);
        chk("rst.nis", {29'd0, nis}, 32'h0);
        chk("rst.n", {31'd0, n}, 32'h0);
        chk("rst.mem_out", mem_out, 32'h0);
        chk("rst.stall", {31'd0, stall}, 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'hDEAD_BEEF;
        cyc();
        chk("rst.late_ack_nis", {29'd0, nis}, 32'h0);
        chk("rst.late_ack_out", mem_out, 32'h0);
        idle();
        cyc();

        // flag_we ignored while stalled
        instr(6'h00, 6'h14, 32'h0000_0300);
        cyc();
        idle();
        flag_we = 1'b1;
        v_in    = 1'b1;
        cyc();
        chk("stallflag.v", {31'd0, v}, 32'h0);
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'h0000_0ABC;
        cyc();
        chk("stallflag.v_at_ack", {31'd0, v}, 32'h0);
        chk("stallflag.nis", {29'd0, nis}, 32'h1);
        mem_rd_ack = 1'b0;
        cyc();
        chk("freeflag.v", {31'd0, v}, 32'h1);

        // stray ack outside a wait
        idle();
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'hFFFF_0000;
        cyc();
        chk("stray.nis", {29'd0, nis}, 32'h0);
        chk("stray.mem_out", mem_out, 32'h0000_0ABC);
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
